// File: rtl/rand_pkg.sv
// Shared types and constants for the random-sample server.
//   RAND_W       : width of one raw LFSR value
//   rand_t       : one raw value / one range value
//   DEFAULT_SEED : reset state of the LFSR
//   s1_t         : first pipeline stage payload {valid, raw, range}
package rand_pkg;

    localparam int unsigned RAND_W = 16;
    localparam int unsigned PROD_W = 2 * RAND_W;

    typedef logic [RAND_W-1:0] rand_t;

    localparam rand_t DEFAULT_SEED = 16'hbeef;

    typedef struct packed {
        logic  valid;
        rand_t raw;
        rand_t range;
    } s1_t;

    // Multiply-shift mapping of raw into [0, range); range 0 passes raw through.
    function automatic rand_t scale(input rand_t raw, input rand_t range);
        if (range == '0) begin
            return raw;
        end
        return RAND_W'((PROD_W'(raw) * PROD_W'(range)) >> RAND_W);
    endfunction

endpackage

// File: rtl/prng.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right, feedback into the MSB.
//   clk   : clock
//   rst   : synchronous reset, active-high; loads SEED
//   en    : advance one step this cycle
//   value : current LFSR state
module prng #(
    parameter logic [15:0] SEED = 16'hbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (en) begin
            value <= {feedback, value[15:1]};
        end
    end

endmodule

// File: rtl/rand_fifo.sv
// Prefetch FIFO for raw LFSR values; pointer + count based, no push-to-pop bypass.
//   clk   : clock
//   rst   : synchronous reset, active-low
//   push  : write din (ignored when full)
//   din   : value to write
//   pop   : drop the head entry (ignored when empty)
//   dout  : current head entry (valid when !empty)
//   full  : DEPTH entries held
//   empty : no entries held
module rand_fifo
    import rand_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  rand_t din,
    input  logic  pop,
    output rand_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    rand_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage: data needs no reset, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rand_sampler.sv
// Random-sample server: prefetches LFSR values and answers range-scaled requests.
//   clk        : clock
//   rst        : synchronous reset, active-low
//   req_valid  : consumer presents a request
//   req_ready  : request accepted this cycle
//   req_range  : number of bins N; 0 selects the full 16-bit range
//   rsp_valid  : response held on rsp_* outputs
//   rsp_ready  : consumer takes the response this cycle
//   rsp_sample : scaled sample in [0, N), raw value when N == 0
//   rsp_raw    : raw LFSR value consumed by this request
module rand_sampler
    import rand_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter rand_t       SEED  = DEFAULT_SEED
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req_valid,
    output logic  req_ready,
    input  rand_t req_range,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output rand_t rsp_sample,
    output rand_t rsp_raw
);

    logic  prng_en;
    rand_t prng_value;
    rand_t fifo_head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  stall;
    logic  xfer;
    s1_t   s1_q;
    s1_t   s1_d;

    // Prefetch only while there is room, so no LFSR value is ever dropped.
    assign prng_en   = rst && !fifo_full;
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = rst && !fifo_empty && !stall;
    assign xfer      = req_valid && req_ready;

    prng #(
        .SEED(SEED)
    ) u_prng (
        .clk  (clk),
        .rst  (~rst),
        .en   (prng_en),
        .value(prng_value)
    );

    rand_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (prng_en),
        .din  (prng_value),
        .pop  (xfer),
        .dout (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Stage 1 payload: head value paired with the request's range.
    always_comb begin
        s1_d       = '0;
        s1_d.valid = xfer;
        s1_d.raw   = fifo_head;
        s1_d.range = req_range;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= '0;
        end else if (!stall) begin
            s1_q <= s1_d;
        end
    end

    // Stage 2: scale and present; data holds its last value across bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid  <= 1'b0;
            rsp_sample <= '0;
            rsp_raw    <= '0;
        end else if (!stall) begin
            rsp_valid <= s1_q.valid;
            if (s1_q.valid) begin
                rsp_sample <= scale(s1_q.raw, s1_q.range);
                rsp_raw    <= s1_q.raw;
            end
        end
    end

endmodule

// File: doc/rand_sampler.md
Name: rand_sampler

Overview:
- Consumer-side server for the 16-bit LFSR random source. Drives the `prng` advance enable, prefetches raw values into a small FIFO, and serves consumer requests over a valid/ready handshake.
- Each response is one raw value plus that value scaled to a requested range [0, N).
- Sits between the `prng` and the path-sampling logic (bounce direction, pixel jitter, Russian roulette).

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- SEED, 16'hbeef, forwarded to the internal `prng` instance.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low; rst==0 resets the block.
- req_valid  input  1  consumer presents a request.
- req_ready  output  1  block accepts the request this cycle.
- req_range  input  16  N, the number of bins; 0 means bypass (full 2^16 range).
- rsp_valid  output  1  response held on rsp_* outputs.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_sample  output  16  scaled sample in [0, N), or the raw value when N==0.
- rsp_raw  output  16  raw LFSR value consumed by this request.

Behaviour:
- Reset (rst==0 at a posedge):
  - FIFO empty; prng state = SEED.
  - rsp_valid=0, rsp_sample=0, rsp_raw=0.
  - Pipeline valid bits cleared. req_ready=0 while in reset.
- prng hookup: the internal `prng` takes an active-high reset, driven with ~rst.
- Fill:
  - prng enable = rst && !fifo_full.
  - On every enabled cycle, the current prng output is pushed and the prng advances.
  - The first value pushed after reset is SEED, then the LFSR successors in order.
  - No value is skipped or duplicated.
- Full FIFO: no push that cycle, even if a pop occurs in the same cycle.
  - The count decrements; the push resumes next cycle.
  - The prng does not advance while disabled.
- Stall: stall = rsp_valid && !rsp_ready. The whole pipeline holds while stalled.
- Accept:
  - req_ready = rst && fifo_count!=0 && !stall.
  - A transfer occurs when req_valid && req_ready.
  - On transfer, the FIFO head is popped into S1 together with req_range.
- Pipeline:
  - S1 registers {raw, range, valid}.
  - S2 computes prod = raw * range as 32-bit unsigned.
  - rsp_sample <= (range==0) ? raw : prod[31:16]. rsp_raw <= raw.
  - Latency: a request accepted at cycle t gives rsp_valid=1 at cycle t+2.
  - Throughput is 1 request/cycle when rsp_ready stays high and the FIFO does not drain.
- Response hold: rsp_* stays stable while rsp_valid && !rsp_ready. rsp_valid deasserts after a transfer only if S1 was empty.
- Bubbles: S1 empty and not stalled means S2 loads rsp_valid=0. The data outputs keep their last value.
- Arithmetic bounds:
  - range==1 always yields 0.
  - range==0xFFFF yields at most 0xFFFE.
  - Bias is the accepted multiply-shift bias; no rejection sampling.
- Reset mid-operation: in-flight requests and prefetched values are discarded. The stream restarts from SEED.
- Ordering: responses return in request order. Raw values are consumed strictly in LFSR sequence order.

Decomposition:
- rand_pkg:
  - RAND_W=16.
  - typedef rand_t = logic[RAND_W-1:0].
  - DEFAULT_SEED=16'hbeef.
  - typedef struct s1_t {valid, raw, range}.
- Sub-module rand_fifo:
  - Parameterised by DEPTH.
  - Pointers plus a count, with full/empty flags.
  - Synchronous active-low reset.
  - No same-cycle bypass from push to pop.
- The existing `prng` module is instantiated unchanged.

Test Plan:
- Reset, then hold req_valid=1, req_range=0, rsp_ready=1 → rsp_raw sequence 0xBEEF, 0x5F77, … with rsp_sample==rsp_raw. First rsp_valid arrives 2 cycles after the first accept.
- Range scaling, req_range=6 on the first two requests → rsp_sample 4 (0xBEEF), then 2 (0x5F77). req_range=0x8000 on 0xBEEF → 0x5F77.
- Edge ranges: range=1 → always 0. range=0xFFFF with raw 0xFFFF (forced via SEED=16'hffff) → 0xFFFE.
- Backpressure:
  - Hold rsp_ready=0 for 10 cycles with requests pending → rsp_* stable and req_ready=0.
  - FIFO fills to DEPTH, then the prng stops advancing.
  - On release, the raw sequence continues with no gap or duplicate against a reference LFSR model.
- Drain, with DEPTH=4 and requests every cycle while the FIFO stays full → no sequence gaps; scoreboard vs the model over 1000 requests with random rsp_ready.
- Mid-stream reset: assert rst=0 for 1 cycle while requests are in flight → rsp_valid=0 next cycle and the first response after reset has raw=0xBEEF.
